intersection_ctrl: RTL and testbench
====================================

// Module: intersection_ctrl
// PURPOSE
//  Two-direction (NS/EW) intersection scheduler that arbitrates one shared crossing between vehicle requesters.
//  Drives six lamp outputs with min/max green, yellow and all-red clearance; all timing in ticks of an external strobe.
//  Sits above the lamp drivers; rests in the last-served green while the other approach is idle.
// PARAMETERS
//  CNT_W        4   phase timer width in bits; every time parameter must be < 2**CNT_W
//  MIN_GREEN    5   minimum green duration (ticks), >=1
//  MAX_GREEN    12  green extension limit (ticks), >=MIN_GREEN
//  YELLOW_TIME  3   yellow duration (ticks), >=1
//  ALL_RED_TIME 1   all-red clearance duration (ticks), >=1
//  WALK_TIME    6   pedestrian walk duration (ticks); used only with PED_CROSS_EN
// PORTS
//  clk        in   1  single clock
//  rst        in   1  reset, asynchronous, active-high
//  tick       in   1  one-cycle timebase strobe; timers advance only on tick
//  ns_req     in   1  NS vehicle detected, level, sampled every clk
//  ew_req     in   1  EW vehicle detected, level, sampled every clk
//  ped_req    in   1  pedestrian button, sampled every clk (PED_CROSS_EN only)
//  ns_green, ns_yellow, ns_red  out 1 each  NS lamps, exactly one high
//  ew_green, ew_yellow, ew_red  out 1 each  EW lamps, exactly one high
//  ped_walk   out  1  walk lamp (PED_CROSS_EN only)
//  phase      out  3  current phase encoding (phase_t)
// BEHAVIOUR
//  Reset, async: phase=NS_GREEN, timer=0, all pending flags=0.
//   ns_green=1, ew_red=1, all other lamps 0, ped_walk=0.
//  Phases: NS_GREEN(0) NS_YELLOW(1) AR_TO_EW(2) EW_GREEN(3) EW_YELLOW(4) AR_TO_NS(5) PED_WALK(6).
//  Lamp outputs: combinational decode of the registered phase, so they change in the same cycle as phase.
//   Both directions are red in AR_* and PED_WALK.
//  Timer: counts ticks completed in the current phase and clears to 0 on every phase change.
//   Saturates at 2**CNT_W-1. elapsed = timer+1, evaluated only in a tick cycle.
//  Pending flags:
//   ew_pend is set by ew_req and cleared on entry to EW_GREEN; ns_pend is set by ns_req and cleared on entry to NS_GREEN.
//   If set and clear fall in the same cycle, clear wins.
//  Green X exits to X_YELLOW on tick when all of the following hold:
//   - elapsed>=MIN_GREEN, and
//   - (opposite pend | ped_pend), and
//   - (!own req | elapsed>=MAX_GREEN).
//   With no pending demand, green is held indefinitely.
//  Fixed-duration phases, each exiting on tick when elapsed equals its time:
//   - X_YELLOW -> AR_TO_<other> after YELLOW_TIME.
//   - AR_TO_Y -> Y_GREEN after ALL_RED_TIME.
//  Each phase therefore lasts exactly N ticks; no transitions without tick. Requests still latch without tick.
//  rst mid-phase: returns to NS_GREEN asynchronously and discards all pending flags.
// CONFIGURATION
//  PED_CROSS_EN defined:
//   - ped_req sets ped_pend; ped_pend forces green exit as above.
//   - AR_TO_Y with ped_pend goes to PED_WALK instead of Y_GREEN; ped_pend clears on PED_WALK entry.
//   - PED_WALK lasts WALK_TIME ticks with ped_walk=1, then goes to Y_GREEN.
//   - ped_req during PED_WALK re-latches for a later cycle.
//  PED_CROSS_EN undefined: ped_req and ped_walk ports absent, PED_WALK unreachable, WALK_TIME unused.
// STRUCTURE
//  Package intersection_pkg: phase_t enum (3-bit encodings above), PHASE_W=3 localparam.
//  One sub-module, phase_timer: tick-enabled saturating counter with synchronous clear-on-phase-change.
//  FSM, pending latches and lamp decode live in intersection_ctrl.
//  Elaboration-time checks enforce the parameter ranges.
// TESTING (defaults; tick every 4 clk)
//  1. Reset, no requests, 50 ticks -> phase stays 0, ns_green=1, ew_red=1 throughout.
//  2. One-clk ew_req pulse at tick 2, ns_req=0 -> NS_YELLOW after 5th tick, AR after 3 more, EW_GREEN after 1 more; ew_pend=0.
//  3. ew_req pulse with ns_req held 1 -> NS_GREEN held until elapsed=12, then NS_YELLOW.
//  4. tick held 0 for 100 clk with ew_req=1 -> phase unchanged; ew_pend=1; first ticks then proceed per scenario 2.
//  5. rst pulsed mid EW_YELLOW -> same-cycle NS_GREEN, lamps at reset values, ns_pend/ew_pend=0.
//  6. PED_CROSS_EN, ped_req in NS_GREEN -> after 5 ticks NS_YELLOW(3), AR(1), PED_WALK(6, ped_walk=1, all red), EW_GREEN.

Source files
------------

// File: rtl/intersection_pkg.sv
`default_nettype none
// ============================================================================
// Module : intersection_pkg
// Brief  : Phase encoding shared by the intersection scheduler and its bench.
// Rev    : 1.0  initial release
// ============================================================================
package intersection_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        AR_TO_EW  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        AR_TO_NS  = 3'd5,
        PED_WALK  = 3'd6
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/intersection_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module : phase_timer
// Brief  : Tick-enabled saturating phase counter with synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Clear has priority so a phase change on a tick restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module : intersection_ctrl
// Brief  : NS/EW intersection scheduler with min/max green, yellow and
//          all-red clearance. Optional pedestrian phase via PED_CROSS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int MIN_GREEN    = 5,
    parameter int MAX_GREEN    = 12,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               ns_req,
    input  logic               ew_req,
`ifdef PED_CROSS_EN
    input  logic               ped_req,
    output logic               ped_walk,
`endif
    output logic               ns_green,
    output logic               ns_yellow,
    output logic               ns_red,
    output logic               ew_green,
    output logic               ew_yellow,
    output logic               ew_red,
    output logic [PHASE_W-1:0] phase
);

    localparam int C_LIMIT = 2 ** CNT_W;

    if ((CNT_W < 1) || (MIN_GREEN < 1) || (MAX_GREEN < MIN_GREEN) ||
        (YELLOW_TIME < 1) || (ALL_RED_TIME < 1) || (WALK_TIME < 1) ||
        (MAX_GREEN >= C_LIMIT) || (YELLOW_TIME >= C_LIMIT) ||
        (ALL_RED_TIME >= C_LIMIT) || (WALK_TIME >= C_LIMIT)) begin : g_param_check
        $error("intersection_ctrl: timing parameter out of range");
    end

    localparam logic [CNT_W:0] c_min_green = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] c_max_green = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] c_yellow    = (CNT_W+1)'(YELLOW_TIME);
    localparam logic [CNT_W:0] c_all_red   = (CNT_W+1)'(ALL_RED_TIME);
`ifdef PED_CROSS_EN
    localparam logic [CNT_W:0] c_walk      = (CNT_W+1)'(WALK_TIME);
`endif

    phase_t           r_phase;
    logic             r_ns_pend;
    logic             r_ew_pend;
    logic             w_ped_pend;
    logic [CNT_W-1:0] w_timer;
    logic [CNT_W:0]   w_elapsed;
    logic             w_exit;
    phase_t           w_next;

`ifdef PED_CROSS_EN
    logic             r_ped_pend;
    logic             r_walk_to_ew;
    assign w_ped_pend = r_ped_pend;
`else
    assign w_ped_pend = 1'b0;
`endif

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_tick  (tick),
        .i_clear (w_exit),
        .o_count (w_timer)
    );

    // One extra bit so a saturated timer still reads as "at least MAX".
    assign w_elapsed = {1'b0, w_timer} + 1'b1;

    always_comb begin
        w_exit = 1'b0;
        w_next = r_phase;
        case (r_phase)
            NS_GREEN: if (tick && (w_elapsed >= c_min_green) && (r_ew_pend || w_ped_pend) &&
                          (!ns_req || (w_elapsed >= c_max_green))) begin
                w_exit = 1'b1;
                w_next = NS_YELLOW;
            end
            NS_YELLOW: if (tick && (w_elapsed == c_yellow)) begin
                w_exit = 1'b1;
                w_next = AR_TO_EW;
            end
            AR_TO_EW: if (tick && (w_elapsed == c_all_red)) begin
                w_exit = 1'b1;
                w_next = w_ped_pend ? PED_WALK : EW_GREEN;
            end
            EW_GREEN: if (tick && (w_elapsed >= c_min_green) && (r_ns_pend || w_ped_pend) &&
                          (!ew_req || (w_elapsed >= c_max_green))) begin
                w_exit = 1'b1;
                w_next = EW_YELLOW;
            end
            EW_YELLOW: if (tick && (w_elapsed == c_yellow)) begin
                w_exit = 1'b1;
                w_next = AR_TO_NS;
            end
            AR_TO_NS: if (tick && (w_elapsed == c_all_red)) begin
                w_exit = 1'b1;
                w_next = w_ped_pend ? PED_WALK : NS_GREEN;
            end
`ifdef PED_CROSS_EN
            PED_WALK: if (tick && (w_elapsed == c_walk)) begin
                w_exit = 1'b1;
                w_next = r_walk_to_ew ? EW_GREEN : NS_GREEN;
            end
`endif
            default: begin
                w_exit = 1'b1;
                w_next = NS_GREEN;
            end
        endcase
    end

    // Pending flags: clearing on entry takes priority over a same-cycle request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= NS_GREEN;
            r_ns_pend <= 1'b0;
            r_ew_pend <= 1'b0;
`ifdef PED_CROSS_EN
            r_ped_pend   <= 1'b0;
            r_walk_to_ew <= 1'b0;
`endif
        end else begin
            if (w_exit) begin
                r_phase <= w_next;
            end
            if (w_exit && (w_next == NS_GREEN)) begin
                r_ns_pend <= 1'b0;
            end else if (ns_req) begin
                r_ns_pend <= 1'b1;
            end
            if (w_exit && (w_next == EW_GREEN)) begin
                r_ew_pend <= 1'b0;
            end else if (ew_req) begin
                r_ew_pend <= 1'b1;
            end
`ifdef PED_CROSS_EN
            if (w_exit && (w_next == PED_WALK)) begin
                r_ped_pend   <= 1'b0;
                r_walk_to_ew <= (r_phase == AR_TO_EW);
            end else if (ped_req) begin
                r_ped_pend <= 1'b1;
            end
`endif
        end
    end

    assign ns_green  = (r_phase == NS_GREEN);
    assign ns_yellow = (r_phase == NS_YELLOW);
    assign ns_red    = !(ns_green || ns_yellow);
    assign ew_green  = (r_phase == EW_GREEN);
    assign ew_yellow = (r_phase == EW_YELLOW);
    assign ew_red    = !(ew_green || ew_yellow);
    assign phase     = r_phase;
`ifdef PED_CROSS_EN
    assign ped_walk  = (r_phase == PED_WALK);
`endif

endmodule
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_intersection_ctrl
// Brief  : Scoreboard bench for intersection_ctrl (tick every 4 clk).
// Rev    : 1.0  initial release
// ============================================================================
module tb_intersection_ctrl;
    import intersection_pkg::*;

    typedef struct {
        phase_t ph;
        int     tk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic ns_req = 1'b0;
    logic ew_req = 1'b0;
    logic ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
    logic [PHASE_W-1:0] phase;
    logic walk_bit;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick_cnt = 0;
    int   cyc_div = 0;
    bit   tick_en = 1'b0;
    bit   mon_en  = 1'b0;
    phase_t exp_phase = NS_GREEN;
    exp_t q[$];

`ifdef PED_CROSS_EN
    logic ped_req = 1'b0;
    logic ped_walk;
    assign walk_bit = ped_walk;
`else
    assign walk_bit = 1'b0;
`endif

    intersection_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .ns_req    (ns_req),
        .ew_req    (ew_req),
`ifdef PED_CROSS_EN
        .ped_req   (ped_req),
        .ped_walk  (ped_walk),
`endif
        .ns_green  (ns_green),
        .ns_yellow (ns_yellow),
        .ns_red    (ns_red),
        .ew_green  (ew_green),
        .ew_yellow (ew_yellow),
        .ew_red    (ew_red),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Timebase: one-cycle tick every 4 clk, restarted whenever disabled.
    initial begin
        forever begin
            @(negedge clk);
            if (!tick_en) begin
                tick = 1'b0;
                cyc_div = 0;
                tick_cnt = 0;
            end else begin
                cyc_div++;
                if (cyc_div == 4) begin
                    cyc_div = 0;
                    tick_cnt++;
                    tick = 1'b1;
                end else begin
                    tick = 1'b0;
                end
            end
        end
    end

    // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    function automatic logic [6:0] lamps_of(phase_t p);
        case (p)
            NS_GREEN:           return 7'b100_001_0;
            NS_YELLOW:          return 7'b010_001_0;
            AR_TO_EW, AR_TO_NS: return 7'b001_001_0;
            EW_GREEN:           return 7'b001_100_0;
            EW_YELLOW:          return 7'b001_010_0;
            PED_WALK:           return 7'b001_001_1;
            default:            return 7'b000_000_0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input phase_t ph, input int tk);
        exp_t e;
        e.ph = ph;
        e.tk = tk;
        q.push_back(e);
    endtask

    task automatic wait_tick(input int n);
        while (tick_cnt < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_ns();
        ns_req = 1'b1;
        @(posedge clk);
        #2;
        ns_req = 1'b0;
    endtask

    task automatic pulse_ew();
        ew_req = 1'b1;
        @(posedge clk);
        #2;
        ew_req = 1'b0;
    endtask

    task automatic do_reset(input bit ticks_on);
        tick_en = 1'b0;
        ns_req  = 1'b0;
        ew_req  = 1'b0;
`ifdef PED_CROSS_EN
        ped_req = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        tick_en = ticks_on;
    endtask

    task automatic check_drained(input string name);
        check(name, q.size(), 0);
        q.delete();
    endtask

    // Monitor: every phase change must match the next scoreboard entry.
    initial begin
        phase_t prev;
        exp_t e;
        prev = NS_GREEN;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            if (phase_t'(phase) != prev) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_phase: got %0d at tick %0d, none expected", phase, tick_cnt);
                end else begin
                    e = q.pop_front();
                    if ((phase !== e.ph) || ((e.tk >= 0) && (tick_cnt != e.tk))) begin
                        n_fail++;
                        $display("FAIL phase_change: got phase %0d at tick %0d, expected phase %0d at tick %0d",
                                 phase, tick_cnt, e.ph, e.tk);
                    end
                    exp_phase = e.ph;
                end
                prev = phase_t'(phase);
            end
            check("lamps", {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk_bit},
                  lamps_of(exp_phase));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b0);
        check("reset_phase", phase, NS_GREEN);
        check("reset_lamps", {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk_bit},
              7'b100_001_0);
        mon_en = 1'b1;

        // 1: idle for 50 ticks, rests in NS green
        tick_en = 1'b1;
        wait_tick(50);
        check("idle_phase", phase, NS_GREEN);
        check_drained("idle_queue");

        // 2: single EW request, then a single NS request back
        do_reset(1'b1);
        push(NS_YELLOW, 5);
        push(AR_TO_EW, 8);
        push(EW_GREEN, 9);
        push(EW_YELLOW, 14);
        push(AR_TO_NS, 17);
        push(NS_GREEN, 18);
        wait_tick(2);
        pulse_ew();
        wait_tick(10);
        check("ew_pend_cleared", dut.r_ew_pend, 0);
        pulse_ns();
        wait_tick(22);
        check_drained("s2_queue");

        // 3: NS held busy extends green to MAX
        do_reset(1'b1);
        ns_req = 1'b1;
        push(NS_YELLOW, 12);
        push(AR_TO_EW, 15);
        push(EW_GREEN, 16);
        push(EW_YELLOW, 21);
        push(AR_TO_NS, 24);
        push(NS_GREEN, 25);
        wait_tick(2);
        pulse_ew();
        wait_tick(27);
        ns_req = 1'b0;
        wait_tick(32);
        check_drained("s3_queue");

        // 4: requests latch while tick is idle
        do_reset(1'b0);
        ew_req = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        ew_req = 1'b0;
        check("notick_phase", phase, NS_GREEN);
        check("notick_ew_pend", dut.r_ew_pend, 1);
        push(NS_YELLOW, 5);
        push(AR_TO_EW, 8);
        push(EW_GREEN, 9);
        push(EW_YELLOW, 14);
        tick_en = 1'b1;
        wait_tick(10);
        pulse_ns();
        wait_tick(15);

        // 5: asynchronous reset in the middle of EW yellow
        pulse_ew();
        check("pre_rst_phase", phase, EW_YELLOW);
        check("pre_rst_ns_pend", dut.r_ns_pend, 1);
        check("pre_rst_ew_pend", dut.r_ew_pend, 1);
        @(posedge clk);
        #2;
        push(NS_GREEN, -1);
        tick_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_phase", phase, NS_GREEN);
        check("rst_lamps", {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk_bit},
              7'b100_001_0);
        check("rst_ns_pend", dut.r_ns_pend, 0);
        check("rst_ew_pend", dut.r_ew_pend, 0);
        do_reset(1'b1);
        wait_tick(4);
        check_drained("s5_queue");

`ifdef PED_CROSS_EN
        // 6: pedestrian request routes through the walk phase
        do_reset(1'b1);
        push(NS_YELLOW, 5);
        push(AR_TO_EW, 8);
        push(PED_WALK, 9);
        push(EW_GREEN, 15);
        wait_tick(1);
        ped_req = 1'b1;
        @(posedge clk);
        #2;
        ped_req = 1'b0;
        wait_tick(20);
        check("ped_end_phase", phase, EW_GREEN);
        check_drained("s6_queue");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
